// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns a UART byte stream into checksummed SOF/opcode/len/payload commands on a valid/ready handshake
module uart_cmd_decoder #(
  parameter int         MAX_PAYLOAD  = 8,
  parameter int         TIMEOUT_CLKS = 208340,
  parameter logic [7:0] SOF          = 8'hA5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rx_dv,
  input  logic [7:0]               rx_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [7:0]               cmd_opcode,
  output logic [3:0]               cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
  output logic                     busy,
  output logic                     err_checksum,
  output logic                     err_length,
  output logic                     err_timeout,
  output logic                     err_overrun
);
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  typedef enum logic [2:0] {HUNT, OPCODE, LENGTH, PAYLOAD, CHECK, HOLD} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               xor_q, xor_d;
  logic [3:0]               idx_q, idx_d;
  logic [7:0]               opcode_q, opcode_d;
  logic [3:0]               len_q, len_d;
  logic [8*MAX_PAYLOAD-1:0] pay_q, pay_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     err_chk_q, err_chk_d;
  logic                     err_len_q, err_len_d;
  logic                     err_to_q, err_to_d;
  logic                     err_ov_q, err_ov_d;
  logic                     active, timeout, len_bad;
  assign active  = state_q inside {OPCODE, LENGTH, PAYLOAD, CHECK};
  assign timeout = active && !rx_dv && cnt_q == CW'(TIMEOUT_CLKS - 1);
  assign len_bad = rx_data > 8'(MAX_PAYLOAD);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= HUNT;
    else          state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = HUNT;
    else case (state_q)
      HUNT:    state_d = (rx_dv && rx_data == SOF) ? OPCODE : HUNT;
      OPCODE:  state_d = rx_dv ? LENGTH : OPCODE;
      LENGTH:  state_d = !rx_dv ? LENGTH : len_bad ? HUNT : (rx_data == 8'd0) ? CHECK : PAYLOAD;
      PAYLOAD: state_d = (rx_dv && idx_q == len_q - 4'd1) ? CHECK : PAYLOAD;
      CHECK:   state_d = !rx_dv ? CHECK : (rx_data == xor_q) ? HOLD : HUNT;
      HOLD:    state_d = (valid_q && cmd_ready) ? HUNT : HOLD;
      default: state_d = HUNT;
    endcase
  end
  always_comb begin
    cnt_d    = (rx_dv || !active) ? '0 : cnt_q + CW'(1);
    xor_d    = xor_q;
    idx_d    = idx_q;
    opcode_d = opcode_q;
    len_d    = len_q;
    pay_d    = pay_q;
    if (rx_dv)
      case (state_q)
        HUNT: if (rx_data == SOF) begin
          pay_d = '0;
          xor_d = '0;
          idx_d = '0;
        end
        OPCODE: begin
          opcode_d = rx_data;
          xor_d    = rx_data;
        end
        LENGTH: begin
          xor_d = xor_q ^ rx_data;
          len_d = len_bad ? len_q : rx_data[3:0];
        end
        PAYLOAD: begin
          pay_d[8*idx_q +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          idx_d = idx_q + 4'd1;
        end
        default: ;
      endcase
    valid_d   = state_d == HOLD;
    busy_d    = state_d != HUNT;
    err_chk_d = state_q == CHECK && rx_dv && rx_data != xor_q;
    err_len_d = state_q == LENGTH && rx_dv && len_bad;
    err_to_d  = timeout;
    err_ov_d  = state_q == HOLD && rx_dv;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt_q     <= '0;
      xor_q     <= '0;
      idx_q     <= '0;
      opcode_q  <= '0;
      len_q     <= '0;
      pay_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      idx_q     <= idx_d;
      opcode_q  <= opcode_d;
      len_q     <= len_d;
      pay_q     <= pay_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      err_ov_q  <= err_ov_d;
    end
  assign cmd_valid    = valid_q;
  assign cmd_opcode   = opcode_q;
  assign cmd_len      = len_q;
  assign cmd_payload  = pay_q;
  assign busy         = busy_q;
  assign err_checksum = err_chk_q;
  assign err_length   = err_len_q;
  assign err_timeout  = err_to_q;
  assign err_overrun  = err_ov_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed frames with hand-computed expectations for uart_cmd_decoder
module tb_uart_cmd_decoder;
  localparam int T = 40;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid, busy, err_checksum, err_length, err_timeout, err_overrun;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  int n_cmp = 0, n_err = 0;
  int n_acc = 0, n_chk = 0, n_len = 0, n_to = 0, n_ov = 0;
  logic [7:0] q[$];
  uart_cmd_decoder #(.MAX_PAYLOAD(8), .TIMEOUT_CLKS(T), .SOF(8'hA5)) dut (
    .clock(clock), .reset_n(reset_n), .rx_dv(rx_dv), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload), .busy(busy),
    .err_checksum(err_checksum), .err_length(err_length),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    n_acc += int'(cmd_valid && cmd_ready);
    n_chk += int'(err_checksum);
    n_len += int'(err_length);
    n_to  += int'(err_timeout);
    n_ov  += int'(err_overrun);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(posedge clock); #1;
    rx_dv = 1'b1;
    rx_data = b;
    @(posedge clock); #1;
    rx_dv = 1'b0;
  endtask
  task automatic send_seq(input logic [7:0] s[$], input int gap);
    foreach (s[i]) begin
      repeat (gap) @(posedge clock);
      send(s[i]);
    end
  endtask
  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_opcode", cmd_opcode, 0);
    chk("rst_len", cmd_len, 0);
    chk("rst_payload", cmd_payload, 0);
    chk("rst_errs", {err_checksum, err_length, err_timeout, err_overrun}, 0);
    reset_n = 1'b1;
    q = '{8'h00, 8'hFF, 8'h5A};
    send_seq(q, 0);
    chk("noise_busy", busy, 0);
    cmd_ready = 1'b1;
    send(8'hA5);
    chk("sof_busy", busy, 1);
    q = '{8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_seq(q, 0);
    chk("ok_valid", cmd_valid, 1);
    chk("ok_opcode", cmd_opcode, 8'h10);
    chk("ok_len", cmd_len, 2);
    chk("ok_payload", cmd_payload, 64'h2211);
    @(posedge clock); #1;
    chk("ok_drop", {cmd_valid, busy}, 0);
    chk("ok_acc", n_acc, 1);
    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
    send_seq(q, 0);
    chk("bad_chk_pulse", err_checksum, 1);
    chk("bad_chk_state", {cmd_valid, busy}, 0);
    @(posedge clock); #1;
    chk("bad_chk_oneshot", err_checksum, 0);
    q = '{8'hA5, 8'h07, 8'h01, 8'h5A, 8'h5C};
    send_seq(q, 0);
    chk("after_bad_valid", cmd_valid, 1);
    chk("after_bad_payload", {cmd_opcode, cmd_len, cmd_payload}, {8'h07, 4'd1, 64'h5A});
    q = '{8'hA5, 8'h33, 8'h09};
    send_seq(q, 0);
    chk("len_err", err_length, 1);
    chk("len_busy", busy, 0);
    q = '{8'h01, 8'h02, 8'h03};
    send_seq(q, 0);
    chk("len_ignored", busy, 0);
    q = '{8'hA5, 8'h33, 8'h00, 8'h33};
    send_seq(q, 0);
    chk("zero_valid", cmd_valid, 1);
    chk("zero_fields", {cmd_opcode, cmd_len, cmd_payload}, {8'h33, 4'd0, 64'h0});
    q = '{8'hA5, 8'h10};
    send_seq(q, 0);
    repeat (T - 1) @(posedge clock);
    #1;
    chk("to_early", {err_timeout, busy}, 2'b01);
    @(posedge clock); #1;
    chk("to_fire", {err_timeout, busy}, 2'b10);
    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_seq(q, T - 4);
    chk("slow_valid", cmd_valid, 1);
    chk("slow_payload", cmd_payload, 64'h2211);
    chk("slow_to_cnt", n_to, 1);
    @(posedge clock); #1;
    cmd_ready = 1'b0;
    q = '{8'hA5, 8'h20, 8'h01, 8'h99, 8'hB8};
    send_seq(q, 0);
    chk("bp_valid", cmd_valid, 1);
    repeat (10) @(posedge clock);
    send(8'hA5);
    chk("bp_overrun", err_overrun, 1);
    chk("bp_hold", {cmd_valid, cmd_opcode, cmd_len, cmd_payload}, {1'b1, 8'h20, 4'd1, 64'h99});
    repeat (38) @(posedge clock);
    #1;
    chk("bp_still", {cmd_valid, cmd_opcode, cmd_payload}, {1'b1, 8'h20, 64'h99});
    rx_dv = 1'b1;
    rx_data = 8'hA5;
    cmd_ready = 1'b1;
    @(posedge clock); #1;
    rx_dv = 1'b0;
    cmd_ready = 1'b0;
    chk("hs_overrun", {err_overrun, cmd_valid, busy}, 3'b100);
    chk("acc_count", n_acc, 5);
    q = '{8'hA5, 8'h10, 8'h04, 8'h01, 8'h02};
    send_seq(q, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {cmd_valid, busy, cmd_opcode, cmd_len, cmd_payload}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    q = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_seq(q, 0);
    chk("post_rst_frame", {cmd_valid, cmd_opcode, cmd_len, cmd_payload}, {1'b1, 8'h10, 4'd2, 64'h2211});
    @(posedge clock); #1;
    chk("err_totals", {n_chk[7:0], n_len[7:0], n_to[7:0], n_ov[7:0]}, 32'h01010102);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
